// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes
// consumed by the control-unit decoder, sequencer state encoding and widths.
package muldiv_seq_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } md_state_t;

    function automatic logic op_is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer: shift-add multiply on {partial, multiplier}
// or restoring trial-subtract divide on {remainder, dividend/quotient}.
module muldiv_step
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     operand,
    input  logic [2*WIDTH-1:0]   acc,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, operand};
        acc_next = acc;
        if (is_div) begin
            // A clear top bit of the difference means the trial subtraction fits.
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_next = {sum, acc[WIDTH-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative mult/multu/div/divu sequencer owning HI/LO; one add/subtract
// step per cycle, with a stall request while an in-flight result is needed.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MdStartE,
    input  logic [1:0]       MdOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             HiLoReadE,
    input  logic             HiWriteE,
    input  logic             LoWriteE,
    output logic             MdBusy,
    output logic             StallMD,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    md_state_t          state, state_next;
    logic [CNTW-1:0]    cnt;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   operand;
    logic               is_div, neg_res, neg_rem, div0;
    logic [WIDTH-1:0]   hi_q, lo_q;

    md_op_t             op;
    logic               sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .operand  (operand),
        .acc      (acc),
        .acc_next (acc_next)
    );

    always_comb begin
        op    = md_op_t'(MdOpE);
        sgn   = op_is_signed(op);
        mag_a = (sgn && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
        mag_b = (sgn && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
        prod  = neg_res ? -acc : acc;
        quot  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (MdStartE) state_next = S_RUN;
            S_RUN:   if (cnt == CNTW'(WIDTH - 1)) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        MdBusy  = (state != S_IDLE);
        StallMD = MdBusy & (MdStartE | HiLoReadE | HiWriteE | LoWriteE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (MdStartE) begin
                        cnt     <= '0;
                        is_div  <= op_is_div(op);
                        neg_res <= sgn & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                        neg_rem <= sgn & SrcAE[WIDTH-1];
                        div0    <= op_is_div(op) && (SrcBE == '0);
                        if (op_is_div(op)) begin
                            acc     <= {{WIDTH{1'b0}}, mag_a};
                            operand <= mag_b;
                        end else begin
                            acc     <= {{WIDTH{1'b0}}, mag_b};
                            operand <= mag_a;
                        end
                    end else begin
                        if (HiWriteE) hi_q <= SrcAE;
                        if (LoWriteE) lo_q <= SrcAE;
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + CNTW'(1);
                end
                S_FIX: begin
                    // Divide-by-zero leaves the dividend in the remainder naturally;
                    // only the quotient needs forcing.
                    if (is_div) begin
                        hi_q <= rem;
                        lo_q <= div0 ? '1 : quot;
                    end else begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign Hi = hi_q;
    assign Lo = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: scoreboard of expected {Hi,Lo} results
// plus per-scenario checks of busy length, stall behaviour and reset abort.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        MdStartE;
    logic [1:0]  MdOpE;
    logic [31:0] SrcAE, SrcBE;
    logic        HiLoReadE, HiWriteE, LoWriteE;
    logic        MdBusy, StallMD;
    logic [31:0] Hi, Lo;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb_q[$];

    muldiv_seq #(.WIDTH(32), .CNTW(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .MdStartE  (MdStartE),
        .MdOpE     (MdOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .HiLoReadE (HiLoReadE),
        .HiWriteE  (HiWriteE),
        .LoWriteE  (LoWriteE),
        .MdBusy    (MdBusy),
        .StallMD   (StallMD),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, m;
        longint unsigned ua, ub;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (op)
            2'b00: r = sa * sb;
            2'b01: r = ua * ub;
            2'b10: begin
                if (b == 32'h0) r = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) r = {a, 32'hFFFFFFFF};
                else r = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit track);
        MdStartE = 1'b1;
        MdOpE    = op;
        SrcAE    = a;
        SrcBE    = b;
        if (track) sb_q.push_back(exp);
        tick();
        MdStartE = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_busy);
        int n;
        bit unstable;
        logic [31:0] hi0, lo0;
        logic [63:0] exp;
        n = 0;
        unstable = 0;
        hi0 = Hi;
        lo0 = Lo;
        while (MdBusy === 1'b1 && n < 200) begin
            if (Hi !== hi0 || Lo !== lo0) unstable = 1;
            n++;
            tick();
        end
        vectors++;
        if (n !== exp_busy) begin
            miscompares++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, n, exp_busy);
        end
        vectors++;
        if (unstable) begin
            miscompares++;
            $display("FAIL %s hilo_stable_during_run got changed want stable", name);
        end
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard_empty got none want entry", name);
        end else begin
            exp = sb_q.pop_front();
            if ({Hi, Lo} !== exp) begin
                miscompares++;
                $display("FAIL %s result got Hi=%h Lo=%h want Hi=%h Lo=%h", name, Hi, Lo, exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        MdStartE = 1'b1;
        HiWriteE = 1'b1;
        SrcAE    = 32'hDEADBEEF;
        tick();
        tick();
        vectors++;
        if (MdBusy !== 1'b0 || StallMD !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state got busy=%b stall=%b Hi=%h Lo=%h want 0 0 0 0", MdBusy, StallMD, Hi, Lo);
        end
        reset    = 1'b0;
        MdStartE = 1'b0;
        HiWriteE = 1'b0;
    endtask

    task automatic test_mult();
        launch(2'b00, 32'h7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1);
        wait_done("mult_7_m3", 33);
        launch(2'b01, 32'hFFFFFFFF, 32'h2, 64'h00000001_FFFFFFFE, 1);
        wait_done("multu_max_2", 33);
        launch(2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1);
        wait_done("mult_minmin", 33);
    endtask

    task automatic test_div();
        launch(2'b10, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 1);
        wait_done("div_m7_2", 33);
        launch(2'b11, 32'hA, 32'h0, 64'h0000000A_FFFFFFFF, 1);
        wait_done("divu_10_0", 33);
        launch(2'b10, 32'hFFFFFFF9, 32'h0, 64'hFFFFFFF9_FFFFFFFF, 1);
        wait_done("div_m7_0", 33);
        launch(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1);
        wait_done("div_min_m1", 33);
        launch(2'b10, 32'h7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1);
        wait_done("div_7_m2", 33);
    endtask

    task automatic test_stall();
        int n, s;
        logic [63:0] exp;
        exp = model(2'b00, 32'h1234, 32'h5678);
        launch(2'b00, 32'h1234, 32'h5678, exp, 0);
        HiLoReadE = 1'b1;
        n = 0;
        s = 0;
        while (MdBusy === 1'b1 && n < 200) begin
            #1;
            if (StallMD === 1'b1) s++;
            n++;
            tick();
        end
        #1;
        vectors++;
        if (n !== 33 || s !== n) begin
            miscompares++;
            $display("FAIL mflo_stall_cycles got stall=%0d busy=%0d want 33 33", s, n);
        end
        vectors++;
        if (StallMD !== 1'b0 || Lo !== exp[31:0]) begin
            miscompares++;
            $display("FAIL mflo_release got stall=%b Lo=%h want 0 %h", StallMD, Lo, exp[31:0]);
        end
        HiLoReadE = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n, s;
        logic [63:0] exp;
        launch(2'b00, 32'hFFFF0001, 32'h00030005, model(2'b00, 32'hFFFF0001, 32'h00030005), 1);
        MdStartE = 1'b1;
        MdOpE    = 2'b01;
        SrcAE    = 32'hCAFEF00D;
        SrcBE    = 32'h9ABCDEF1;
        n = 0;
        s = 0;
        while (MdBusy === 1'b1 && n < 200) begin
            if (StallMD === 1'b1) s++;
            n++;
            tick();
        end
        vectors++;
        if (n !== 33 || s !== 33) begin
            miscompares++;
            $display("FAIL b2b_first_busy got busy=%0d stall=%0d want 33 33", n, s);
        end
        vectors++;
        exp = sb_q.pop_front();
        if ({Hi, Lo} !== exp) begin
            miscompares++;
            $display("FAIL b2b_first_result got %h want %h", {Hi, Lo}, exp);
        end
        sb_q.push_back(model(2'b01, 32'hCAFEF00D, 32'h9ABCDEF1));
        tick();
        vectors++;
        if (MdBusy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second_accept got busy=%b want 1", MdBusy);
        end
        MdStartE = 1'b0;
        SrcAE    = 32'h11111111;
        SrcBE    = 32'h22222222;
        MdOpE    = 2'b10;
        wait_done("b2b_second", 33);
    endtask

    task automatic test_write_while_busy();
        LoWriteE = 1'b1;
        SrcAE    = 32'h00000BAD;
        tick();
        LoWriteE = 1'b0;
        vectors++;
        if (Lo !== 32'h00000BAD) begin
            miscompares++;
            $display("FAIL mtlo_idle got %h want 00000bad", Lo);
        end
        LoWriteE = 1'b1;
        launch(2'b01, 32'h3, 32'h5, 64'h00000000_0000000F, 1);
        LoWriteE = 1'b0;
        vectors++;
        if (Lo !== 32'h00000BAD) begin
            miscompares++;
            $display("FAIL start_beats_mtlo got Lo=%h want 00000bad", Lo);
        end
        HiWriteE = 1'b1;
        SrcAE    = 32'hDEADDEAD;
        #1;
        vectors++;
        if (StallMD !== 1'b1) begin
            miscompares++;
            $display("FAIL mthi_busy_stall got %b want 1", StallMD);
        end
        tick();
        HiWriteE = 1'b0;
        wait_done("mthi_ignored_busy", 32);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 4 == 3) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            launch(op, a, b, model(op, a, b), 1);
            wait_done("random", 33);
        end
    endtask

    task automatic test_reset_abort();
        HiWriteE = 1'b1;
        SrcAE    = 32'h1234;
        tick();
        HiWriteE = 1'b0;
        LoWriteE = 1'b1;
        SrcAE    = 32'h5678;
        tick();
        LoWriteE = 1'b0;
        vectors++;
        if (Hi !== 32'h1234 || Lo !== 32'h5678) begin
            miscompares++;
            $display("FAIL preload_hilo got Hi=%h Lo=%h want 00001234 00005678", Hi, Lo);
        end
        launch(2'b10, 32'd1000, 32'd7, 64'h0, 0);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (MdBusy !== 1'b0 || StallMD !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_abort got busy=%b stall=%b Hi=%h Lo=%h want 0 0 0 0", MdBusy, StallMD, Hi, Lo);
        end
        LoWriteE = 1'b1;
        SrcAE    = 32'hABCD;
        tick();
        LoWriteE = 1'b0;
        vectors++;
        if (Lo !== 32'hABCD || Hi !== 32'h0 || MdBusy !== 1'b0) begin
            miscompares++;
            $display("FAIL mtlo_after_abort got Lo=%h Hi=%h busy=%b want 0000abcd 0 0", Lo, Hi, MdBusy);
        end
    endtask

    initial begin
        reset     = 1'b1;
        MdStartE  = 1'b0;
        MdOpE     = 2'b00;
        SrcAE     = '0;
        SrcBE     = '0;
        HiLoReadE = 1'b0;
        HiWriteE  = 1'b0;
        LoWriteE  = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_back_to_back();
        test_write_while_busy();
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the pipelined MIPS CPU. It executes mult, multu, div and divu, and owns the HI/LO register pair.
- It sits beside the EX-stage ALU. The EX stage launches operations into it, and it raises a stall request to the hazard logic while an in-flight result is still needed.
- One 32-bit add/subtract step per cycle, so no wide combinational multiplier or divider.

Parameters:
- WIDTH, 32, operand width and HI/LO width.
- CNTW, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- MdStartE  in  1  EX-stage instruction is mult/multu/div/divu.
- MdOpE  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- SrcAE  in  WIDTH  rs operand (multiplicand or dividend).
- SrcBE  in  WIDTH  rt operand (multiplier or divisor).
- HiLoReadE  in  1  EX-stage instruction is mfhi/mflo.
- HiWriteE  in  1  EX-stage instruction is mthi; data on SrcAE.
- LoWriteE  in  1  EX-stage instruction is mtlo; data on SrcAE.
- MdBusy  out  1  operation in flight.
- StallMD  out  1  stall request to the hazard unit (freeze F/D/E, bubble M).
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
- Reset: state IDLE, counter 0, Hi=0, Lo=0, MdBusy=0, StallMD=0. Reset mid-operation aborts immediately, with no HI/LO update. Reset dominates all inputs.
- States and transitions:
  - IDLE: if MdStartE, latch operands and op, take magnitudes for signed ops, record sign flags, clear counter, go to RUN.
  - RUN: one iteration per cycle; after WIDTH iterations (counter = WIDTH-1), go to FIX.
  - FIX: apply sign correction, write Hi/Lo, go to IDLE.
- Latency: the start is accepted at edge T. MdBusy is high from T+1 through T+WIDTH+1 (33 cycles at the default). Hi/Lo update at edge T+WIDTH+1 and are valid in the cycle MdBusy falls.
- Multiply: shift-add on a 2*WIDTH accumulator. Signed ops multiply magnitudes and negate the 64-bit product if the operand signs differ. Product {Hi,Lo}.
- Divide: restoring, one quotient bit per cycle on magnitudes. Quotient is negated if signs differ; remainder takes the sign of the dividend. Lo=quotient, Hi=remainder.
- Divide by zero (both div and divu): Lo=all ones, Hi=dividend as given (unsigned pattern). No trap.
- div 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. This falls out of magnitude arithmetic modulo 2^WIDTH.
- MdBusy=1 means state != IDLE.
- StallMD = MdBusy & (MdStartE | HiLoReadE | HiWriteE | LoWriteE). It is combinational from state and inputs, with no extra cycle.
- MdStartE while busy is ignored. The pipeline holds the instruction in EX, and it is accepted at the first IDLE edge.
- mthi/mtlo: written at the edge only when IDLE. If HiWriteE/LoWriteE and MdStartE are both asserted (not producible by decode), the start wins and the write is dropped.
- Hi/Lo are stable during RUN. Partial results live in internal registers only.
- Operands are latched at acceptance, so later changes on SrcAE/SrcBE have no effect.

Decomposition:
- Shared package: MdOp encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), state encodings (S_IDLE, S_RUN, S_FIX), WIDTH default. The decoder in the control unit consumes the same MdOp constants.
- One natural sub-module, muldiv_step: combinational single iteration (shift-add or trial-subtract) on accumulator/remainder. The sequencer holds the FSM, counter, sign flags and HI/LO.

Test Plan:
1. mult, SrcAE=7, SrcBE=0xFFFFFFFD -> MdBusy high 33 cycles, then Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
2. multu, SrcAE=0xFFFFFFFF, SrcBE=2 -> Hi=0x00000001, Lo=0xFFFFFFFE.
3. div, SrcAE=0xFFFFFFF9 (-7), SrcBE=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
   divu 10/0 -> Lo=0xFFFFFFFF, Hi=0x0000000A.
4. mult then mflo issued on the next cycle -> StallMD=1 for exactly the cycles MdBusy=1; mflo sees the new Lo on release.
   Back-to-back mult/mult -> second accepted on the cycle after MdBusy falls.
5. Reset asserted at iteration 10 of a div with Hi/Lo previously 0x1234/0x5678 -> next cycle IDLE, MdBusy=0, Hi=Lo=0.
   A subsequent mtlo 0xABCD writes Lo=0xABCD at the next edge.
